// File: rtl/spi_multichannel_receiver.sv
// SPI mode-0 slave: a frame is a channel index followed by a payload, committed on the last SCLK rise
// with no extra latency; no backpressure, and a toggle strobe per channel hands each write to the 50 MHz domain.
module spi_multichannel_receiver #(
  parameter  int FRAME_BITS   = 16,
  parameter  int CH_BITS      = 2,
  parameter  int NUM_CHANNELS = 2,
  parameter  bit LSB_FIRST    = 1'b0,
  localparam int PAYLOAD_BITS = FRAME_BITS - CH_BITS
) (
  input  logic                                 input_SPI_SCLK,
  input  logic                                 reset_n,
  input  logic                                 input_SPI_CS_n,
  input  logic                                 input_SPI_SDO,
  output logic [NUM_CHANNELS*PAYLOAD_BITS-1:0] channel_data,
  output logic [NUM_CHANNELS-1:0]              channel_update_toggle,
  output logic [CH_BITS-1:0]                   last_channel,
  output logic [7:0]                           frame_error_count,
  output logic                                 receiving
);

  localparam int CW = $clog2(FRAME_BITS + 2);

  logic [CH_BITS-1:0]      ch_sr;
  logic [PAYLOAD_BITS-1:0] pl_sr;
  logic [PAYLOAD_BITS-1:0] pl_next;
  logic [CW-1:0]           bit_cnt;
  logic                    overrun;
  logic                    in_ch_field;
  logic                    frame_done;
  logic                    extra_edge;
  logic                    ch_valid;

  assign in_ch_field = bit_cnt < CW'(CH_BITS);
  assign frame_done  = bit_cnt == CW'(FRAME_BITS - 1);
  assign extra_edge  = (bit_cnt >= CW'(FRAME_BITS)) && !overrun;
  assign ch_valid    = {1'b0, ch_sr} < (CH_BITS + 1)'(NUM_CHANNELS);

  // The completing edge's bit is folded in here so the commit sees the whole frame.
  always_comb begin
    pl_next = '0;
    if (LSB_FIRST)
      pl_next = (pl_sr >> 1) | (PAYLOAD_BITS'(input_SPI_SDO) << (PAYLOAD_BITS - 1));
    else
      pl_next = (pl_sr << 1) | PAYLOAD_BITS'(input_SPI_SDO);
  end

  always_ff @(posedge input_SPI_SCLK or negedge reset_n or posedge input_SPI_CS_n) begin
    if (!reset_n) begin
      ch_sr     <= '0;
      pl_sr     <= '0;
      bit_cnt   <= '0;
      overrun   <= 1'b0;
      receiving <= 1'b0;
    end else if (input_SPI_CS_n) begin
      ch_sr     <= '0;
      pl_sr     <= '0;
      bit_cnt   <= '0;
      overrun   <= 1'b0;
      receiving <= 1'b0;
    end else begin
      if (bit_cnt != CW'(FRAME_BITS + 1))
        bit_cnt <= bit_cnt + CW'(1);
      if (in_ch_field)
        ch_sr <= (ch_sr << 1) | CH_BITS'(input_SPI_SDO);
      else if (bit_cnt < CW'(FRAME_BITS))
        pl_sr <= pl_next;
      receiving <= bit_cnt < CW'(FRAME_BITS - 1);
      if (bit_cnt >= CW'(FRAME_BITS))
        overrun <= 1'b1;
    end
  end

  always_ff @(posedge input_SPI_SCLK or negedge reset_n) begin
    if (!reset_n) begin
      channel_data          <= '0;
      channel_update_toggle <= '0;
      last_channel          <= '0;
      frame_error_count     <= '0;
    end else if (!input_SPI_CS_n) begin
      if (frame_done) begin
        if (ch_valid) begin
          for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (ch_sr == CH_BITS'(k)) begin
              channel_data[k*PAYLOAD_BITS +: PAYLOAD_BITS] <= pl_next;
              channel_update_toggle[k]                     <= ~channel_update_toggle[k];
            end
          end
          last_channel <= ch_sr;
        end else if (frame_error_count != 8'hFF) begin
          frame_error_count <= frame_error_count + 8'd1;
        end
      end
      // Counted once per CS window: the overrun flag blocks later extra edges.
      if (extra_edge && frame_error_count != 8'hFF)
        frame_error_count <= frame_error_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_spi_multichannel_receiver.sv
// Scoreboarded bench: default-parameter receiver plus an LSB-first 12-bit variant.
module tb_spi_multichannel_receiver;

  localparam int FB = 16, CB = 2, NC = 2, PB = 14;
  localparam int FB2 = 12, PB2 = 11;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic reset_n, cs_n, sdo, cs2_n, sdo2;
  logic [NC*PB-1:0] channel_data;
  logic [NC-1:0]    tog;
  logic [CB-1:0]    last;
  logic [7:0]       err;
  logic             rcv;
  logic [2*PB2-1:0] data2;
  logic [1:0]       tog2;
  logic [0:0]       last2;
  logic [7:0]       err2;
  logic             rcv2;

  spi_multichannel_receiver dut (
    .input_SPI_SCLK(sclk), .reset_n(reset_n), .input_SPI_CS_n(cs_n), .input_SPI_SDO(sdo),
    .channel_data(channel_data), .channel_update_toggle(tog), .last_channel(last),
    .frame_error_count(err), .receiving(rcv));

  spi_multichannel_receiver #(.FRAME_BITS(FB2), .CH_BITS(1), .NUM_CHANNELS(2), .LSB_FIRST(1'b1)) dut2 (
    .input_SPI_SCLK(sclk), .reset_n(reset_n), .input_SPI_CS_n(cs2_n), .input_SPI_SDO(sdo2),
    .channel_data(data2), .channel_update_toggle(tog2), .last_channel(last2),
    .frame_error_count(err2), .receiving(rcv2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per-channel payloads and counters, updated from whole frames.
  typedef struct {
    logic [NC*PB-1:0] data;
    logic [NC-1:0]    tog;
    logic [CB-1:0]    last;
    logic [7:0]       err;
  } exp_t;

  exp_t          sb[$];
  logic [PB-1:0] m_data[NC];
  logic [NC-1:0] m_tog;
  logic [CB-1:0] m_last;
  int            m_err;
  logic [PB2-1:0] m2_data[2];
  logic [1:0]     m2_tog;

  function automatic exp_t snap();
    exp_t e;
    for (int k = 0; k < NC; k++) e.data[k*PB +: PB] = m_data[k];
    e.tog  = m_tog;
    e.last = m_last;
    e.err  = 8'(m_err);
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) m_data[k] = '0;
    m_tog = '0; m_last = '0; m_err = 0;
    m2_data[0] = '0; m2_data[1] = '0; m2_tog = '0;
  endtask

  task automatic model_frame(input logic [15:0] word, input int nbits);
    int ch;
    if (nbits < FB) return;
    ch = int'(word) / (1 << PB);
    if (ch < NC) begin
      m_data[ch] = PB'(int'(word) % (1 << PB));
      m_tog[ch]  = ~m_tog[ch];
      m_last     = CB'(ch);
    end else begin
      m_err = (m_err < 255) ? m_err + 1 : 255;
    end
    sb.push_back(snap());
    if (nbits > FB) begin
      m_err = (m_err < 255) ? m_err + 1 : 255;
      sb.push_back(snap());
    end
  endtask

  // Monitor: any toggle or error-count change is one DUT event, matched against the scoreboard.
  logic [NC-1:0] prev_tog = '0;
  logic [7:0]    prev_err = '0;
  always begin
    exp_t e;
    @(posedge sclk);
    #1;
    if (!reset_n) begin
      prev_tog = '0;
      prev_err = '0;
    end else if (tog !== prev_tog || err !== prev_err) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got tog=%b err=%0d, expected no change", tog, err);
      end else begin
        e = sb.pop_front();
        check("ev_data", 64'(channel_data), 64'(e.data));
        check("ev_toggle", 64'(tog), 64'(e.tog));
        check("ev_last", 64'(last), 64'(e.last));
        check("ev_err", 64'(err), 64'(e.err));
      end
      prev_tog = tog;
      prev_err = err;
    end
  end

  task automatic send1(input logic [15:0] word, input int nbits);
    model_frame(word, nbits);
    @(negedge sclk);
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      sdo = (i < FB) ? word[15-i] : 1'($urandom);
      @(negedge sclk);
      if (i == 0) check("receiving_first", 64'(rcv), 64'd1);
    end
    check("receiving_end", 64'(rcv), (nbits < FB) ? 64'd1 : 64'd0);
    cs_n = 1'b1;
    @(negedge sclk);
    check("receiving_idle", 64'(rcv), 64'd0);
  endtask

  task automatic send2(input logic ch, input logic [PB2-1:0] payload);
    @(negedge sclk);
    cs2_n = 1'b0;
    for (int i = 0; i < FB2; i++) begin
      sdo2 = (i == 0) ? ch : payload[i-1];
      @(negedge sclk);
    end
    cs2_n = 1'b1;
    m2_data[ch] = payload;
    m2_tog[ch]  = ~m2_tog[ch];
    @(negedge sclk);
    check("lsb_data", 64'(data2[ch*PB2 +: PB2]), 64'(m2_data[ch]));
    check("lsb_other", 64'(data2[(1-ch)*PB2 +: PB2]), 64'(m2_data[1-ch]));
    check("lsb_toggle", 64'(tog2), 64'(m2_tog));
    check("lsb_last", 64'(last2), 64'(ch));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 64'(channel_data), 64'd0);
    check({tag, "_toggle"}, 64'(tog), 64'd0);
    check({tag, "_last"}, 64'(last), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_receiving"}, 64'(rcv), 64'd0);
    check({tag, "_data2"}, 64'(data2), 64'd0);
    check({tag, "_toggle2"}, 64'(tog2), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; cs_n = 1'b1; sdo = 1'b0; cs2_n = 1'b1; sdo2 = 1'b0;
    model_reset();
    repeat (3) @(negedge sclk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge sclk);

    send1(16'h1ABC, 16);
    send1(16'h40FF, 16);
    send1(16'hC123, 16);
    send1(16'h2AAA, 10);
    send1(16'h0005, 20);
    send2(1'b1, 11'h3C5);
    send2(1'b0, 11'h012);

    repeat (3) @(negedge sclk);
    check("sb_drained_before_reset", 64'(sb.size()), 64'd0);
    @(negedge sclk);
    cs_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sdo = 1'($urandom);
      @(negedge sclk);
    end
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge sclk);
    check_all_zero("midframe_reset");
    reset_n = 1'b1;
    cs_n = 1'b1;
    @(negedge sclk);
    send1(16'h5A5A, 16);

    for (int n = 0; n < 40; n++) begin
      logic [15:0] w;
      int kind, nb;
      w = 16'($urandom);
      kind = $urandom_range(0, 9);
      nb = (kind < 7) ? FB : (kind < 9) ? $urandom_range(1, FB - 1) : $urandom_range(FB + 1, FB + 4);
      send1(w, nb);
      if (n % 8 == 0) send2(1'($urandom), 11'($urandom));
    end

    repeat (4) @(negedge sclk);
    check("sb_drained_end", 64'(sb.size()), 64'd0);
    check("final_err", 64'(err), 64'(m_err));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
